// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_e;

  // Counter must be able to hold the value WidthB itself.
  function automatic int cnt_width(input int width_b);
    return $clog2(width_b + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, sign handled as
// magnitude multiply followed by a conditional negate.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WidthA = 8,
  parameter int WidthB = 8,
  parameter int Signed = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WidthA-1:0]        data_in1_i,
  input  logic [WidthB-1:0]        data_in2_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WidthA+WidthB-1:0] data_out_o,
  output logic                     busy_o
);

  localparam int ProdW = WidthA + WidthB;
  localparam int CntW  = cnt_width(WidthB);

  mult_state_e       r_state;
  mult_state_e       w_state_next;
  logic [WidthA-1:0] r_a;
  logic [WidthB-1:0] r_b;
  logic [ProdW-1:0]  r_acc;
  logic [ProdW-1:0]  r_out;
  logic [CntW-1:0]   r_cnt;
  logic              r_neg;

  logic              w_accept;
  logic              w_last;
  logic              w_neg_in;
  logic [WidthA-1:0] w_a_mag;
  logic [WidthB-1:0] w_b_mag;
  logic [ProdW-1:0]  w_addend;
  logic [ProdW-1:0]  w_acc_next;
  logic [ProdW-1:0]  w_result;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and out_valid_o stays high with
  // data_out_o frozen until the consumer takes it.
  assign in_ready_o  = (r_state == IDLE);
  assign out_valid_o = (r_state == DONE);
  assign busy_o      = (r_state != IDLE);
  assign data_out_o  = r_out;

  assign w_accept = in_valid_i && in_ready_o;
  assign w_last   = (r_cnt == CntW'(WidthB - 1));

  assign w_a_mag  = (Signed != 0 && data_in1_i[WidthA-1]) ? -data_in1_i : data_in1_i;
  assign w_b_mag  = (Signed != 0 && data_in2_i[WidthB-1]) ? -data_in2_i : data_in2_i;
  assign w_neg_in = (Signed != 0) ? (data_in1_i[WidthA-1] ^ data_in2_i[WidthB-1]) : 1'b0;

  assign w_addend   = r_b[0] ? (ProdW'(r_a) << r_cnt) : '0;
  assign w_acc_next = r_acc + w_addend;
  assign w_result   = r_neg ? -w_acc_next : w_acc_next;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = BUSY;
      BUSY:    if (w_last) w_state_next = DONE;
      DONE:    if (out_ready_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= w_a_mag;
            r_b   <= w_b_mag;
            r_neg <= w_neg_in;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        BUSY: begin
          r_acc <= w_acc_next;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CntW'(1);
          if (w_last) r_out <= w_result;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: four instances (8x8 unsigned/signed, 12x4 unsigned/signed)
// driven through a shared operand bus, results checked from an expected queue.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in_valid = '0;
  logic [3:0]  out_ready = '1;
  logic [11:0] data_a = '0;
  logic [7:0]  data_b = '0;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  busy;
  logic [15:0] data_out [4];

  logic [15:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  typedef struct {
    int          sel;
    logic [11:0] a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_multiplier #(.WidthA(8), .WidthB(8), .Signed(0)) u_dut_u8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .data_in1_i(data_a[7:0]), .data_in2_i(data_b), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .data_out_o(data_out[0]), .busy_o(busy[0]));

  seq_multiplier #(.WidthA(8), .WidthB(8), .Signed(1)) u_dut_s8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .data_in1_i(data_a[7:0]), .data_in2_i(data_b), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .data_out_o(data_out[1]), .busy_o(busy[1]));

  seq_multiplier #(.WidthA(12), .WidthB(4), .Signed(0)) u_dut_u12 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .data_in1_i(data_a), .data_in2_i(data_b[3:0]), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready[2]), .data_out_o(data_out[2]), .busy_o(busy[2]));

  seq_multiplier #(.WidthA(12), .WidthB(4), .Signed(1)) u_dut_s12 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[3]), .in_ready_o(in_ready[3]),
    .data_in1_i(data_a), .data_in2_i(data_b[3:0]), .out_valid_o(out_valid[3]),
    .out_ready_i(out_ready[3]), .data_out_o(data_out[3]), .busy_o(busy[3]));

  // Reference product: mask operands to the instance widths, sign-extend a and b
  // when the instance is signed, multiply in 64 bits, keep the low 16 bits.
  function automatic logic [15:0] model(input int sel, input logic [11:0] a, input logic [7:0] b);
    int          wa;
    int          wb;
    bit          sgn;
    longint      av;
    longint      bv;
    logic [63:0] prod;
    wa  = (sel < 2) ? 8 : 12;
    wb  = (sel < 2) ? 8 : 4;
    sgn = (sel == 1) || (sel == 3);
    av  = longint'(a) & ((64'sd1 << wa) - 1);
    bv  = longint'(b) & ((64'sd1 << wb) - 1);
    if (sgn && av >= (64'sd1 << (wa - 1))) av -= (64'sd1 << wa);
    if (sgn && bv >= (64'sd1 << (wb - 1))) bv -= (64'sd1 << wb);
    prod = 64'(av * bv);
    return prod[15:0];
  endfunction

  // Present operands until the instance takes them; returns at #1 into the first BUSY cycle.
  task automatic drive_op(input int sel, input logic [11:0] a, input logic [7:0] b,
                          input logic [15:0] p, input bit push);
    bit took  = 1'b0;
    int guard = 0;
    data_a        = a;
    data_b        = b;
    in_valid[sel] = 1'b1;
    if (push) exp_q.push_back(p);
    while (!took && guard < 50) begin
      took = in_ready[sel];
      @(posedge clk); #1;
      guard++;
    end
    in_valid[sel] = 1'b0;
    if (!took) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout sel=%0d in_ready=%b required=1", sel, in_ready[sel]);
    end
  endtask

  // Cycle index after the accept cycle at which out_valid is first seen (bounded).
  task automatic wait_out(input int sel, output int lat);
    lat = 1;
    while (!out_valid[sel] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    int          lat;
    rst         = 1'b1;
    in_valid[0] = 1'b1;
    data_a      = 12'd6;
    data_b      = 8'd9;
    exp_q.push_back(16'd54);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (in_ready[i] !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", i, in_ready[i]); end
      n_vec++;
      if (out_valid[i] !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", i, out_valid[i]); end
      n_vec++;
      if (busy[i] !== 1'b0) begin n_miss++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, busy[i]); end
      n_vec++;
      if (data_out[i] !== 16'h0) begin n_miss++; $display("FAIL reset_data_out[%0d] got=%h exp=0000", i, data_out[i]); end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    n_vec++;
    if (busy[0] !== 1'b1) begin n_miss++; $display("FAIL accept_after_reset busy got=%b exp=1", busy[0]); end
    wait_out(0, lat);
    n_vec++;
    if (out_valid[0] !== 1'b1 || lat != 9) begin
      n_miss++; $display("FAIL post_reset_latency got=%0d exp=9", lat);
    end
    exp = exp_q.pop_front();
    n_vec++;
    if (data_out[0] !== exp) begin n_miss++; $display("FAIL post_reset_product got=%h exp=%h", data_out[0], exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    vec_t        tbl[6];
    logic [15:0] exp;
    int          lat;
    tbl = '{'{0, 12'd2, 8'd7, 16'd14}, '{0, 12'd211, 8'd98, 16'd20678},
            '{0, 12'd123, 8'd77, 16'd9471}, '{0, 12'd0, 8'd0, 16'd0},
            '{0, 12'd255, 8'd255, 16'd65025}, '{0, 12'd0, 8'd200, 16'd0}};
    foreach (tbl[i]) begin
      drive_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].p, 1'b1);
      wait_out(tbl[i].sel, lat);
      n_vec++;
      if (out_valid[tbl[i].sel] !== 1'b1 || lat != 9) begin
        n_miss++; $display("FAIL unsigned_latency #%0d got=%0d exp=9", i, lat);
      end
      exp = exp_q.pop_front();
      n_vec++;
      if (data_out[tbl[i].sel] !== exp) begin
        n_miss++; $display("FAIL unsigned_product #%0d got=%h exp=%h", i, data_out[tbl[i].sel], exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_signed();
    vec_t        tbl[5];
    logic [15:0] exp;
    int          lat;
    tbl = '{'{1, 12'h080, 8'h80, 16'd16384}, '{1, 12'h07F, 8'h80, 16'hC080},
            '{1, 12'h0FF, 8'h01, 16'hFFFF}, '{1, 12'h005, 8'hF9, 16'hFFDD},
            '{1, 12'h000, 8'h80, 16'h0000}};
    foreach (tbl[i]) begin
      drive_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].p, 1'b1);
      wait_out(tbl[i].sel, lat);
      n_vec++;
      if (out_valid[tbl[i].sel] !== 1'b1 || lat != 9) begin
        n_miss++; $display("FAIL signed_latency #%0d got=%0d exp=9", i, lat);
      end
      exp = exp_q.pop_front();
      n_vec++;
      if (data_out[tbl[i].sel] !== exp) begin
        n_miss++; $display("FAIL signed_product #%0d got=%h exp=%h", i, data_out[tbl[i].sel], exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    int          lat;
    out_ready[0] = 1'b0;
    drive_op(0, 12'd13, 8'd11, 16'd143, 1'b1);
    wait_out(0, lat);
    n_vec++;
    if (out_valid[0] !== 1'b1 || lat != 9) begin n_miss++; $display("FAIL bp_latency got=%0d exp=9", lat); end
    exp = exp_q.pop_front();
    n_vec++;
    if (data_out[0] !== exp) begin n_miss++; $display("FAIL bp_product got=%h exp=%h", data_out[0], exp); end
    data_a      = 12'd99;
    data_b      = 8'd99;
    in_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || data_out[0] !== exp) begin
        n_miss++;
        $display("FAIL bp_hold cyc%0d valid=%b ready=%b data=%h exp valid=1 ready=0 data=%h",
                 k, out_valid[0], in_ready[0], data_out[0], exp);
      end
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_miss++;
      $display("FAIL bp_release valid=%b ready=%b busy=%b exp 0/1/0", out_valid[0], in_ready[0], busy[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    int          lat;
    int          t1;
    drive_op(0, 12'd17, 8'd19, 16'd323, 1'b1);
    wait_out(0, lat);
    t1  = cyc;
    exp = exp_q.pop_front();
    n_vec++;
    if (out_valid[0] !== 1'b1 || data_out[0] !== exp) begin
      n_miss++; $display("FAIL b2b_first got=%h exp=%h", data_out[0], exp);
    end
    drive_op(0, 12'd21, 8'd23, 16'd483, 1'b1);
    wait_out(0, lat);
    n_vec++;
    if (out_valid[0] !== 1'b1 || (cyc - t1) != 10) begin
      n_miss++; $display("FAIL b2b_spacing got=%0d exp=10", cyc - t1);
    end
    exp = exp_q.pop_front();
    n_vec++;
    if (data_out[0] !== exp) begin n_miss++; $display("FAIL b2b_second got=%h exp=%h", data_out[0], exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_busy();
    logic [15:0] exp;
    int          lat;
    drive_op(0, 12'd200, 8'd200, 16'd0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || data_out[0] !== 16'h0) begin
      n_miss++;
      $display("FAIL mid_busy_reset valid=%b ready=%b busy=%b data=%h exp 0/1/0/0000",
               out_valid[0], in_ready[0], busy[0], data_out[0]);
    end
    drive_op(0, 12'd3, 8'd5, 16'd15, 1'b1);
    wait_out(0, lat);
    n_vec++;
    if (out_valid[0] !== 1'b1 || lat != 9) begin n_miss++; $display("FAIL mid_busy_latency got=%0d exp=9", lat); end
    exp = exp_q.pop_front();
    n_vec++;
    if (data_out[0] !== exp) begin n_miss++; $display("FAIL mid_busy_next got=%h exp=%h", data_out[0], exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_width();
    vec_t        tbl[5];
    logic [15:0] exp;
    int          lat;
    tbl = '{'{2, 12'd4095, 8'd15, 16'd61425}, '{2, 12'd0, 8'd15, 16'd0},
            '{3, 12'h800, 8'h08, 16'h4000}, '{3, 12'h7FF, 8'h08, 16'hC008},
            '{3, 12'hFFF, 8'h07, 16'hFFF9}};
    foreach (tbl[i]) begin
      drive_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].p, 1'b1);
      wait_out(tbl[i].sel, lat);
      n_vec++;
      if (out_valid[tbl[i].sel] !== 1'b1 || lat != 5) begin
        n_miss++; $display("FAIL width_latency #%0d got=%0d exp=5", i, lat);
      end
      exp = exp_q.pop_front();
      n_vec++;
      if (data_out[tbl[i].sel] !== exp) begin
        n_miss++; $display("FAIL width_product #%0d got=%h exp=%h", i, data_out[tbl[i].sel], exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic [7:0]  b;
    logic [15:0] exp;
    int          lat;
    int          n;
    for (int sel = 0; sel < 4; sel++) begin
      n = (sel < 2) ? 200 : 1000;
      for (int k = 0; k < n; k++) begin
        a = 12'($urandom_range(0, 4095));
        b = 8'($urandom_range(0, 255));
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        drive_op(sel, a, b, model(sel, a, b), 1'b1);
        wait_out(sel, lat);
        n_vec++;
        if (out_valid[sel] !== 1'b1 || lat != ((sel < 2) ? 9 : 5)) begin
          n_miss++; $display("FAIL rand_latency sel=%0d got=%0d", sel, lat);
        end
        exp = exp_q.pop_front();
        n_vec++;
        if (data_out[sel] !== exp) begin
          n_miss++; $display("FAIL rand_product sel=%0d a=%h b=%h got=%h exp=%h", sel, a, b, data_out[sel], exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    test_width();
    test_random();
    n_vec++;
    if (exp_q.size() != 0) begin n_miss++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
